i2c_slave_regfile: RTL and testbench
====================================

Name: i2c_slave_regfile

Overview:
Parametrised, fully synchronous I2C slave with an addressable register file. It is the next generation of the team's I2C slave. SCL/SDA are oversampled on the system clock, so no logic is clocked by SCL. It adds open-drain output enables, a host-side register port, register-pointer wrap and a range check, a write-strobe to user logic, and optional clock stretching.

Parameters:
NUM_REGS, 16, number of 8-bit registers (2..256).
REG_AW, 4, register pointer width; must equal clog2(NUM_REGS).
SYNC_STAGES, 2, synchroniser depth on scl_i/sda_i (>=2).
STRETCH_CYCLES, 8, clk cycles SCL is held low after each ACK (used only with the optional feature).

Ports:
clk  in  1  system clock, at least 8x SCL rate
rst  in  1  asynchronous reset, active-high
slave_addr  in  7  device address, static during a transfer
scl_i  in  1  SCL pad input
sda_i  in  1  SDA pad input
sda_oe  out  1  1 = pull SDA low
scl_oe  out  1  1 = pull SCL low (constant 0 without the optional feature)
host_we  in  1  host register write
host_addr  in  REG_AW  host register address
host_wdata  in  8  host write data
host_rdata  out  8  combinational read of regs[host_addr]
i2c_wr_stb  out  1  one-clk pulse per byte written over I2C
i2c_wr_addr  out  REG_AW  register written (valid with strobe)
i2c_wr_data  out  8  byte written (valid with strobe)
busy  out  1  high from addressed-ACK until STOP or a non-matching address

Behaviour:
- Reset values: sda_oe=0, scl_oe=0, i2c_wr_stb=0, busy=0, all regs=0x00, pointer=0, state IDLE.
- scl_i and sda_i each pass through SYNC_STAGES flops. Edges are detected against the previous synchronised sample.
- START = SDA falls while SCL high. STOP = SDA rises while SCL high. Both are recognised in any state.
- START (including repeated START) -> ADDR, bit counter cleared.
- STOP -> IDLE, sda_oe=0, busy=0.
- Data bits are sampled on the SCL rising edge, MSB first. sda_oe changes only on a detected SCL falling edge.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. If {addr[6:0]} matches slave_addr -> ACK_A. Otherwise -> IGNORE until START or STOP.
  - ACK_A: drive ACK for one SCL period. R/W=0 -> REG. R/W=1 -> RD, with the read byte loaded from regs[pointer].
  - REG: shift 8 bits. Value < NUM_REGS -> load pointer, go to ACK_R with ACK. Otherwise NACK (sda_oe=0) -> IGNORE.
  - WR: shift 8 bits -> ACK_W. On the 8th rising edge write regs[pointer]. i2c_wr_stb pulses one clk with the pre-increment address. Pointer then increments.
  - RD: drive the byte (sda_oe = ~bit). After 8 bits release SDA and go to MACK.
  - MACK: sample SDA on rising edge. 0 (ACK) -> increment pointer, load the next byte, go to RD. 1 (NACK) -> IGNORE.
- Pointer wraps from NUM_REGS-1 to 0.
- A host write to the same register in the same clk as an I2C write: host_we wins, and i2c_wr_stb still pulses.
- A read byte is captured at load time. Host writes during shift do not alter the bits on the wire.
- Reset mid-transfer: immediate return to reset values; the bus is released within 0 clk (async).

Optional Feature:
Macro I2C_SLAVE_STRETCH_EN.
- Defined: after each slave-driven ACK (ACK_A, ACK_R, ACK_W) and before each RD byte, assert scl_oe on the SCL falling edge for STRETCH_CYCLES clks, then release. The FSM ignores SCL edges while scl_oe=1.
- Undefined: scl_oe tied 0, no stretch logic.

Test Plan:
- Reset -> sda_oe=0, scl_oe=0, busy=0, host_rdata=0x00 for all host_addr.
- slave_addr=0x50: write 0xA0,0x03,0x11,0x22, STOP -> each byte ACKed; regs[3]=0x11, regs[4]=0x22; two i2c_wr_stb pulses (addr 3/0x11, addr 4/0x22).
- Host writes regs[15]=0x5A, regs[0]=0xC3. I2C: 0xA0,0x0F, repeated START, 0xA1, read 2 bytes (ACK then NACK) -> SDA shows 0x5A then 0xC3 (wrap); STOP -> busy=0.
- Address 0xA2 with slave_addr=0x50 -> no ACK, sda_oe stays 0, busy=0, no writes. Register byte 0x20 -> NACK, no write.
- Assert rst mid-RD while driving a 0 bit -> sda_oe=0 immediately, regs=0. A following valid write transfer succeeds.
- I2C_SLAVE_STRETCH_EN defined, STRETCH_CYCLES=8 -> scl_oe high exactly 8 clk after each ACK; data is still correct when the master waits on SCL.

Source files
------------

// File: rtl/i2c_slave_regfile.sv
// I2C slave with an oversampled SCL/SDA front end, 8-bit register file and host port.
// Optional SCL clock stretching after each slave ACK is enabled by defining I2C_SLAVE_STRETCH_EN.
`timescale 1ns/1ps
module i2c_slave_regfile #(
    parameter int NUM_REGS       = 16,
    parameter int REG_AW         = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int STRETCH_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        slave_addr,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe,
    output logic              scl_oe,
    input  logic              host_we,
    input  logic [REG_AW-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    output logic [7:0]        host_rdata,
    output logic              i2c_wr_stb,
    output logic [REG_AW-1:0] i2c_wr_addr,
    output logic [7:0]        i2c_wr_data,
    output logic              busy
);

    if (REG_AW != $clog2(NUM_REGS) || NUM_REGS < 2 || NUM_REGS > 256 ||
        SYNC_STAGES < 2 || STRETCH_CYCLES < 1) begin : g_param_check
        $error("i2c_slave_regfile: illegal parameter set");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ACK_A, S_REG, S_ACK_R, S_WR, S_ACK_W, S_RD, S_MACK, S_IGNORE
    } state_t;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  scl_sync, sda_sync;
    logic                    scl_s, sda_s, scl_d, sda_d;
    logic                    scl_rise, scl_fall, start_c, stop_c;
    logic [3:0]              bit_cnt;
    logic [7:0]              shreg, rx_byte, load_byte;
    logic [REG_AW-1:0]       pointer, next_ptr, load_ptr;
    logic                    rw, ack_phase, i2c_we, host_in_range;
    logic [7:0]              regs [NUM_REGS];

    // Sync flops reset to the idle-bus level so reset release never fakes an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign sda_s    = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_d & ~scl_oe;
    assign scl_fall = ~scl_s & scl_d & ~scl_oe;
    assign start_c  = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_c   = scl_s & scl_d & ~sda_d & sda_s;
    assign rx_byte  = {shreg[6:0], sda_s};

    always_comb begin
        next_ptr      = (pointer == REG_AW'(NUM_REGS - 1)) ? '0 : pointer + 1'b1;
        load_ptr      = (state == S_MACK) ? next_ptr : pointer;
        load_byte     = regs[load_ptr];
        host_in_range = (32'(host_addr) < NUM_REGS);
        host_rdata    = host_in_range ? regs[host_addr] : '0;
        i2c_we        = (state == S_WR) && scl_rise && (bit_cnt == 4'd7) && !start_c && !stop_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            // Host port takes priority on a same-register collision
            if (i2c_we && !(host_we && host_addr == pointer)) regs[pointer] <= rx_byte;
            if (host_we && host_in_range) regs[host_addr] <= host_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            pointer     <= '0;
            rw          <= 1'b0;
            ack_phase   <= 1'b0;
            sda_oe      <= 1'b0;
            busy        <= 1'b0;
            i2c_wr_stb  <= 1'b0;
            i2c_wr_addr <= '0;
            i2c_wr_data <= '0;
        end else begin
            i2c_wr_stb <= 1'b0;
            if (stop_c) begin
                state     <= S_IDLE;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
                ack_phase <= 1'b0;
            end else if (start_c) begin
                state     <= S_ADDR;
                bit_cnt   <= '0;
                sda_oe    <= 1'b0;
                ack_phase <= 1'b0;
            end else begin
                case (state)
                    S_ADDR: if (scl_rise) begin
                        shreg <= rx_byte;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= '0;
                            if (rx_byte[7:1] == slave_addr) begin
                                rw    <= rx_byte[0];
                                busy  <= 1'b1;
                                state <= S_ACK_A;
                            end else begin
                                busy  <= 1'b0;
                                state <= S_IGNORE;
                            end
                        end else bit_cnt <= bit_cnt + 1'b1;
                    end
                    S_REG: if (scl_rise) begin
                        shreg <= rx_byte;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= '0;
                            if ({1'b0, rx_byte} < 9'(NUM_REGS)) begin
                                pointer <= rx_byte[REG_AW-1:0];
                                state   <= S_ACK_R;
                            end else state <= S_IGNORE;
                        end else bit_cnt <= bit_cnt + 1'b1;
                    end
                    S_WR: if (scl_rise) begin
                        shreg <= rx_byte;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt     <= '0;
                            i2c_wr_stb  <= 1'b1;
                            i2c_wr_addr <= pointer;
                            i2c_wr_data <= rx_byte;
                            pointer     <= next_ptr;
                            state       <= S_ACK_W;
                        end else bit_cnt <= bit_cnt + 1'b1;
                    end
                    // First fall asserts ACK, second fall ends the ACK slot
                    S_ACK_A, S_ACK_R, S_ACK_W: if (scl_fall) begin
                        if (!ack_phase) begin
                            sda_oe    <= 1'b1;
                            ack_phase <= 1'b1;
                        end else begin
                            ack_phase <= 1'b0;
                            bit_cnt   <= '0;
                            if (state == S_ACK_A && rw) begin
                                shreg  <= load_byte;
                                sda_oe <= ~load_byte[7];
                                state  <= S_RD;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= (state == S_ACK_A) ? S_REG : S_WR;
                            end
                        end
                    end
                    S_RD: if (scl_rise) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            bit_cnt <= '0;
                            sda_oe  <= 1'b0;
                            state   <= S_MACK;
                        end else begin
                            sda_oe <= ~shreg[6];
                            shreg  <= {shreg[6:0], 1'b0};
                        end
                    end
                    S_MACK: if (scl_rise) begin
                        if (sda_s) state <= S_IGNORE;
                        else       ack_phase <= 1'b1;
                    end else if (scl_fall && ack_phase) begin
                        ack_phase <= 1'b0;
                        pointer   <= next_ptr;
                        shreg     <= load_byte;
                        sda_oe    <= ~load_byte[7];
                        bit_cnt   <= '0;
                        state     <= S_RD;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef I2C_SLAVE_STRETCH_EN
    localparam int SCW = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
    logic [SCW-1:0] stretch_cnt;
    logic           stretch_go;

    // The fall that closes an ACK slot or starts a read byte opens the stretch
    always_comb begin
        stretch_go = scl_fall && ack_phase && !start_c && !stop_c &&
                     (state == S_ACK_A || state == S_ACK_R || state == S_ACK_W || state == S_MACK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_oe      <= 1'b0;
            stretch_cnt <= '0;
        end else if (scl_oe) begin
            if (stretch_cnt == '0) scl_oe <= 1'b0;
            else                   stretch_cnt <= stretch_cnt - 1'b1;
        end else if (stretch_go) begin
            scl_oe      <= 1'b1;
            stretch_cnt <= SCW'(STRETCH_CYCLES - 1);
        end
    end
`else
    assign scl_oe = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: bit-banged open-drain I2C master plus host-port vector tables.
`timescale 1ns/1ps
module tb_i2c_slave_regfile;
    localparam int NUM_REGS = 16;
    localparam int REG_AW   = 4;
    localparam int STRETCH  = 8;
    localparam int Q        = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [6:0]        slave_addr = 7'h50;
    logic              scl_m = 1'b1, sda_m = 1'b1;
    logic              scl_bus, sda_bus;
    logic              sda_oe, scl_oe, busy, i2c_wr_stb;
    logic              host_we = 1'b0;
    logic [REG_AW-1:0] host_addr = '0;
    logic [7:0]        host_wdata = '0, host_rdata, i2c_wr_data;
    logic [REG_AW-1:0] i2c_wr_addr;

    assign scl_bus = scl_m & ~scl_oe;
    assign sda_bus = sda_m & ~sda_oe;
    always #5 clk = ~clk;

    i2c_slave_regfile #(.NUM_REGS(NUM_REGS), .REG_AW(REG_AW), .SYNC_STAGES(2), .STRETCH_CYCLES(STRETCH)) dut (
        .clk(clk), .rst(rst), .slave_addr(slave_addr), .scl_i(scl_bus), .sda_i(sda_bus),
        .sda_oe(sda_oe), .scl_oe(scl_oe), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata), .i2c_wr_stb(i2c_wr_stb),
        .i2c_wr_addr(i2c_wr_addr), .i2c_wr_data(i2c_wr_data), .busy(busy)
    );

    int n_vec = 0, n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Bus monitors: only this block writes these
    int          sda_cnt = 0, wr_cnt = 0, scl_run = 0, scl_hi_cnt = 0, stretch_runs = 0, stretch_bad = 0;
    logic [3:0]  wr_addr_log [64];
    logic [7:0]  wr_data_log [64];
    always @(negedge clk) begin
        if (sda_oe) sda_cnt++;
        if (i2c_wr_stb && wr_cnt < 64) begin
            wr_addr_log[wr_cnt] = i2c_wr_addr;
            wr_data_log[wr_cnt] = i2c_wr_data;
            wr_cnt++;
        end
        if (scl_oe) begin
            scl_run++;
            scl_hi_cnt++;
        end else if (scl_run != 0) begin
            if (scl_run != STRETCH) stretch_bad++;
            stretch_runs++;
            scl_run = 0;
        end
    end

    typedef struct {
        int         grp;
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } hvec_t;
    hvec_t vecs[$];

    function automatic hvec_t hv(int g, logic we, logic [3:0] a, logic [7:0] w, logic [7:0] e);
        hvec_t v;
        v.grp = g; v.we = we; v.addr = a; v.wdata = w; v.exp = e;
        return v;
    endfunction

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_group(input int g);
        foreach (vecs[i]) begin
            if (vecs[i].grp == g) begin
                @(negedge clk);
                host_addr  = vecs[i].addr;
                host_wdata = vecs[i].wdata;
                host_we    = vecs[i].we;
                if (vecs[i].we) begin
                    @(negedge clk);
                    host_we = 1'b0;
                end
                #1 check($sformatf("host_g%0d_reg%0d", g, vecs[i].addr), host_rdata, vecs[i].exp);
            end
        end
    endtask

    task automatic scl_high();
        scl_m = 1'b1;
        for (int i = 0; i < 200 && scl_bus !== 1'b1; i++) @(negedge clk);
        if (scl_bus !== 1'b1) check("scl_release_timeout", scl_bus, 1);
    endtask

    task automatic clock_bit(input logic b, output logic r);
        sda_m = b;
        wclk(Q);
        scl_high();
        wclk(Q);
        r = sda_bus;
        wclk(Q);
        scl_m = 1'b0;
        wclk(Q);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        wclk(Q);
        scl_high();
        wclk(Q);
        sda_m = 1'b0;
        wclk(Q);
        scl_m = 1'b0;
        wclk(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        wclk(Q);
        scl_high();
        wclk(Q);
        sda_m = 1'b1;
        wclk(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], r);
        clock_bit(1'b1, r);
        ack = ~r;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] b);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, r);
            b[i] = r;
        end
        clock_bit(~mack, r);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack;
        logic [7:0] rb;
        int         s0;

        for (int i = 0; i < NUM_REGS; i++) vecs.push_back(hv(0, 1'b0, 4'(i), 8'h00, 8'h00));
        vecs.push_back(hv(1, 1'b0, 4'd3,  8'h00, 8'h11));
        vecs.push_back(hv(1, 1'b0, 4'd4,  8'h00, 8'h22));
        vecs.push_back(hv(1, 1'b0, 4'd2,  8'h00, 8'h00));
        vecs.push_back(hv(1, 1'b0, 4'd5,  8'h00, 8'h00));
        vecs.push_back(hv(2, 1'b1, 4'd15, 8'h5A, 8'h5A));
        vecs.push_back(hv(2, 1'b1, 4'd0,  8'hC3, 8'hC3));
        vecs.push_back(hv(2, 1'b0, 4'd3,  8'h00, 8'h11));
        vecs.push_back(hv(3, 1'b0, 4'd0,  8'h00, 8'hC3));
        vecs.push_back(hv(3, 1'b0, 4'd15, 8'h00, 8'h5A));
        vecs.push_back(hv(3, 1'b0, 4'd4,  8'h00, 8'h22));
        vecs.push_back(hv(4, 1'b1, 4'd1,  8'h0F, 8'h0F));
        vecs.push_back(hv(5, 1'b0, 4'd7,  8'h00, 8'h99));
        vecs.push_back(hv(5, 1'b0, 4'd1,  8'h00, 8'h00));

        // Reset state
        wclk(5);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_scl_oe", scl_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_stb", i2c_wr_stb, 0);
        rst = 1'b0;
        wclk(5);
        run_group(0);

        // Write 0x11, 0x22 starting at register 3
        i2c_start();
        write_byte(8'hA0, ack); check("wr_ack_addr", ack, 1);
        write_byte(8'h03, ack); check("wr_ack_reg", ack, 1);
        write_byte(8'h11, ack); check("wr_ack_d0", ack, 1);
        write_byte(8'h22, ack); check("wr_ack_d1", ack, 1);
        check("wr_busy", busy, 1);
        i2c_stop();
        check("wr_busy_after_stop", busy, 0);
        check("wr_stb_count", wr_cnt, 2);
        check("wr_stb0_addr", wr_addr_log[0], 3);
        check("wr_stb0_data", wr_data_log[0], 8'h11);
        check("wr_stb1_addr", wr_addr_log[1], 4);
        check("wr_stb1_data", wr_data_log[1], 8'h22);
        run_group(1);

        // Host writes, then pointer 15 read with wrap to 0 via repeated START
        run_group(2);
        i2c_start();
        write_byte(8'hA0, ack); check("rd_ack_addr_w", ack, 1);
        write_byte(8'h0F, ack); check("rd_ack_reg", ack, 1);
        i2c_start();
        write_byte(8'hA1, ack); check("rd_ack_addr_r", ack, 1);
        read_byte(1'b1, rb); check("rd_byte0", rb, 8'h5A);
        read_byte(1'b0, rb); check("rd_byte1_wrap", rb, 8'hC3);
        check("rd_busy", busy, 1);
        i2c_stop();
        check("rd_busy_after_stop", busy, 0);
        check("rd_no_writes", wr_cnt, 2);

        // Non-matching address, then out-of-range register byte
        s0 = sda_cnt;
        i2c_start();
        write_byte(8'hA2, ack); check("bad_addr_nack", ack, 0);
        check("bad_addr_sda_idle", sda_cnt - s0, 0);
        check("bad_addr_busy", busy, 0);
        write_byte(8'h00, ack); check("bad_addr_data_nack", ack, 0);
        i2c_stop();
        i2c_start();
        write_byte(8'hA0, ack); check("range_ack_addr", ack, 1);
        s0 = sda_cnt;
        write_byte(8'h20, ack); check("range_reg_nack", ack, 0);
        check("range_sda_idle", sda_cnt - s0, 0);
        write_byte(8'h77, ack); check("range_data_nack", ack, 0);
        i2c_stop();
        check("range_no_writes", wr_cnt, 2);
        run_group(3);

        // Reset while the slave drives a 0 data bit
        run_group(4);
        i2c_start();
        write_byte(8'hA0, ack); check("mid_ack_addr_w", ack, 1);
        write_byte(8'h01, ack); check("mid_ack_reg", ack, 1);
        i2c_start();
        write_byte(8'hA1, ack); check("mid_ack_addr_r", ack, 1);
        wclk(5);
        check("mid_driving_zero", sda_oe, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_sda_oe", sda_oe, 0);
        check("mid_rst_busy", busy, 0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        wclk(5);
        run_group(0);
        rst = 1'b0;
        wclk(5);
        i2c_start();
        write_byte(8'hA0, ack); check("post_ack_addr", ack, 1);
        write_byte(8'h07, ack); check("post_ack_reg", ack, 1);
        write_byte(8'h99, ack); check("post_ack_data", ack, 1);
        i2c_stop();
        check("post_stb_count", wr_cnt, 3);
        check("post_stb_addr", wr_addr_log[2], 7);
        check("post_stb_data", wr_data_log[2], 8'h99);
        run_group(5);

`ifdef I2C_SLAVE_STRETCH_EN
        check("stretch_runs_seen", (stretch_runs > 0) ? 1 : 0, 1);
        check("stretch_len_errors", stretch_bad, 0);
`else
        check("scl_oe_never_high", scl_hi_cnt, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
